// File: rtl/minimal_dma_sched_pkg.sv
// -----------------------------------------------------------------------------
// minimal_dma_sched_pkg
//   Shared types and constants for the MINIMAL_DMA transaction scheduler.
//   - sched_state_e : scheduler FSM states
//   - CNT_W         : width of the statistics counters
//   - tmo_cnt_width : width of a counter that must reach TIMEOUT_CYCLES-1
// -----------------------------------------------------------------------------
package minimal_dma_sched_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LAUNCH   = 2'd1,
        WAIT     = 2'd2,
        COMPLETE = 2'd3
    } sched_state_e;

    localparam int CNT_W = 16;

    // The timeout counter only has to hold 0..TIMEOUT_CYCLES-1.
    function automatic int tmo_cnt_width(input int timeout_cycles);
        int w;
        w = $clog2(timeout_cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/minimal_dma_sched_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin pick. The search begins at start_idx and wraps
//   around; the first asserted request wins.
//   Ports:
//     req        in  NUM_REQ  request vector
//     start_idx  in  IDX_W    index where the search begins
//     gnt_valid  out 1        at least one request is asserted
//     gnt_onehot out NUM_REQ  one-hot winner (all zero when gnt_valid = 0)
//     gnt_idx    out IDX_W    binary index of the winner
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   start_idx,
    output logic               gnt_valid,
    output logic [NUM_REQ-1:0] gnt_onehot,
    output logic [IDX_W-1:0]   gnt_idx
);

    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        // NOTE: every output of a combinational block gets a default before
        // any conditional assignment; a path that leaves one unassigned
        // infers a latch.
        gnt_valid  = 1'b0;
        gnt_onehot = '0;
        gnt_idx    = '0;
        cand       = 0;
        cand_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(start_idx) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = IDX_W'(cand);
            if (!gnt_valid && req[cand_idx]) begin
                gnt_valid            = 1'b1;
                gnt_onehot[cand_idx] = 1'b1;
                gnt_idx              = cand_idx;
            end
        end
    end

endmodule

// File: rtl/minimal_dma_sched.sv
// -----------------------------------------------------------------------------
// minimal_dma_sched
//   Shares one MINIMAL_DMA AXI master between NUM_REQ requesters. A round-robin
//   winner is granted, the DMA is started with a one-cycle init pulse, and the
//   scheduler waits for the DMA done edge (or a timeout) before returning a
//   done/error pulse to the owner.
//   Ports:
//     ACLK               in  1        clock, rising edge
//     ARESETN            in  1        asynchronous active-low reset
//     req                in  NUM_REQ  level requests, held until req_done
//     grant              out NUM_REQ  one-hot owner of the in-flight transaction
//     req_done           out NUM_REQ  one-cycle completion pulse to the owner
//     req_err            out NUM_REQ  error qualifier, valid with req_done
//     M_AXI_INIT_AXI_TXN out 1        one-cycle DMA start pulse
//     M_AXI_TXN_DONE     in  1        DMA done level (high until next start)
//     M_AXI_ERROR        in  1        DMA error level, sampled at the done edge
//     busy               out 1        scheduler not in IDLE
//     timeout_sticky     out 1        any timeout since reset
//     txn_count          out 16       completed transactions (wrapping)
//     err_count          out 16       errored transactions (saturating)
// -----------------------------------------------------------------------------
module minimal_dma_sched
    import minimal_dma_sched_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic               ACLK,
    input  logic               ARESETN,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [NUM_REQ-1:0] req_done,
    output logic [NUM_REQ-1:0] req_err,
    output logic               M_AXI_INIT_AXI_TXN,
    input  logic               M_AXI_TXN_DONE,
    input  logic               M_AXI_ERROR,
    output logic               busy,
    output logic               timeout_sticky,
    output logic [CNT_W-1:0]   txn_count,
    output logic [CNT_W-1:0]   err_count
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TMO_W = tmo_cnt_width(TIMEOUT_CYCLES);

    sched_state_e       state_q, state_d;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W-1:0]   rr_start;     // where the next search begins
    logic [TMO_W-1:0]   tmo_cnt;
    logic               done_q;
    logic               err_q;

    logic               arb_valid;
    logic [NUM_REQ-1:0] arb_onehot;
    logic [IDX_W-1:0]   arb_idx;

    logic               done_edge;
    logic               tmo_hit;
    logic               finish;
    logic               finish_err;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req        (req),
        .start_idx  (rr_start),
        .gnt_valid  (arb_valid),
        .gnt_onehot (arb_onehot),
        .gnt_idx    (arb_idx)
    );

    // A done level left high by the previous transaction produces no edge,
    // so only a fresh completion is recognised.
    assign done_edge = M_AXI_TXN_DONE & ~done_q;
    assign tmo_hit   = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    // Done edge has priority over the timeout terminal count.
    assign finish     = (state_q == WAIT) && (done_edge || tmo_hit);
    assign finish_err = done_edge ? M_AXI_ERROR : 1'b1;

    // Decoded from the state register so reset removes them immediately.
    assign M_AXI_INIT_AXI_TXN = (state_q == LAUNCH);
    assign busy               = (state_q != IDLE);
    assign req_done           = (state_q == COMPLETE) ? grant : '0;
    assign req_err            = (state_q == COMPLETE && err_q) ? grant : '0;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (arb_valid) state_d = LAUNCH;
            LAUNCH:   state_d = WAIT;
            WAIT:     if (done_edge || tmo_hit) state_d = COMPLETE;
            COMPLETE: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q <= IDLE;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every flop
            // samples pre-edge values regardless of process ordering.
            state_q <= state_d;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            grant          <= '0;
            grant_idx      <= '0;
            rr_start       <= '0;
            tmo_cnt        <= '0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
            timeout_sticky <= 1'b0;
            txn_count      <= '0;
            err_count      <= '0;
        end else begin
            done_q <= M_AXI_TXN_DONE;

            unique case (state_q)
                IDLE: begin
                    if (arb_valid) begin
                        grant     <= arb_onehot;
                        grant_idx <= arb_idx;
                    end
                end
                LAUNCH: begin
                    tmo_cnt <= '0;
                end
                WAIT: begin
                    if (done_edge) begin
                        err_q <= M_AXI_ERROR;
                    end else if (tmo_hit) begin
                        err_q          <= 1'b1;
                        timeout_sticky <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                COMPLETE: begin
                    grant    <= '0;
                    rr_start <= (grant_idx == IDX_W'(NUM_REQ - 1)) ?
                                '0 : grant_idx + IDX_W'(1);
                end
                default: ;
            endcase

            // Statistics change on entry to COMPLETE so they are visible in
            // the same cycle as the req_done pulse.
            if (finish) begin
                txn_count <= txn_count + CNT_W'(1);
                if (finish_err && (err_count != {CNT_W{1'b1}})) begin
                    err_count <= err_count + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_minimal_dma_sched.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_minimal_dma_sched
//   Scoreboard bench. dut_a (default timeout) is served by a behavioural DMA
//   model; dut_b (TIMEOUT_CYCLES = 16) has its done/error pins driven directly
//   for the timeout corner cases. Expected completions are queued by the
//   stimulus and popped by one monitor per DUT.
// -----------------------------------------------------------------------------
module tb_minimal_dma_sched;

    localparam int N = 4;

    typedef struct {
        logic [N-1:0] done;
        logic [N-1:0] err;
        logic [15:0]  txn;
        logic [15:0]  errc;
        logic         sticky;
        int           lat;      // cycles from init pulse to req_done
    } exp_t;

    logic tb_ACLK = 1'b0;
    logic ARESETN;

    logic [N-1:0] req_a, grant_a, req_done_a, req_err_a;
    logic         init_a, done_a, merr_a, busy_a, sticky_a;
    logic [15:0]  txn_a, errc_a;

    logic [N-1:0] req_b, grant_b, req_done_b, req_err_b;
    logic         init_b, done_b, merr_b, busy_b, sticky_b;
    logic [15:0]  txn_b, errc_b;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int   a_lat  = 3;
    int   a_fall = 1;
    logic a_err  = 1'b0;

    int   init_cyc_a = 0, init_cyc_b = 0;
    int   n_init_a   = 0;
    logic prev_init_a = 1'b0, prev_init_b = 1'b0;

    minimal_dma_sched #(.NUM_REQ(N)) dut_a (
        .ACLK               (tb_ACLK),
        .ARESETN            (ARESETN),
        .req                (req_a),
        .grant              (grant_a),
        .req_done           (req_done_a),
        .req_err            (req_err_a),
        .M_AXI_INIT_AXI_TXN (init_a),
        .M_AXI_TXN_DONE     (done_a),
        .M_AXI_ERROR        (merr_a),
        .busy               (busy_a),
        .timeout_sticky     (sticky_a),
        .txn_count          (txn_a),
        .err_count          (errc_a)
    );

    minimal_dma_sched #(.NUM_REQ(N), .TIMEOUT_CYCLES(16)) dut_b (
        .ACLK               (tb_ACLK),
        .ARESETN            (ARESETN),
        .req                (req_b),
        .grant              (grant_b),
        .req_done           (req_done_b),
        .req_err            (req_err_b),
        .M_AXI_INIT_AXI_TXN (init_b),
        .M_AXI_TXN_DONE     (done_b),
        .M_AXI_ERROR        (merr_b),
        .busy               (busy_b),
        .timeout_sticky     (sticky_b),
        .txn_count          (txn_b),
        .err_count          (errc_b)
    );

    always #5 tb_ACLK = ~tb_ACLK;

    always @(posedge tb_ACLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input logic [N-1:0] d, input logic e, input int t,
                                input int ec, input logic s, input int lat);
        exp_t r;
        r.done   = d;
        r.err    = e ? d : '0;
        r.txn    = 16'(t);
        r.errc   = 16'(ec);
        r.sticky = s;
        r.lat    = lat;
        return r;
    endfunction

    task automatic compare(input string tag, input exp_t e, input logic [N-1:0] d,
                           input logic [N-1:0] er, input logic [15:0] t, input logic [15:0] ec,
                           input logic s, input int lat);
        check({tag, "_req_done"}, 32'(d), 32'(e.done));
        check({tag, "_req_err"},  32'(er), 32'(e.err));
        check({tag, "_txn_count"}, 32'(t), 32'(e.txn));
        check({tag, "_err_count"}, 32'(ec), 32'(e.errc));
        check({tag, "_timeout_sticky"}, 32'(s), 32'(e.sticky));
        check({tag, "_latency"}, lat, e.lat);
    endtask

    // which: 0 = req_done_a, 1 = req_done_b, 2 = init_b. Returns at the
    // negedge where the event is seen, or when the budget expires.
    task automatic wait_sig(input int which, input int budget, input string name);
        int   i;
        logic hit;
        i = 0;
        do begin
            @(negedge tb_ACLK);
            i++;
            hit = (which == 0) ? (req_done_a != '0) :
                  (which == 1) ? (req_done_b != '0) : init_b;
        end while (!hit && i < budget);
        check(name, 32'(hit), 32'd1);
    endtask

    // Behavioural DMA for dut_a: after a start pulse the done level drops at
    // cycle a_fall and rises again at cycle a_lat with error a_err.
    initial begin
        done_a = 1'b0;
        merr_a = 1'b0;
        forever begin
            @(negedge tb_ACLK);
            if (ARESETN && init_a) begin
                for (int k = 1; k <= a_lat; k++) begin
                    @(posedge tb_ACLK);
                    #1;
                    if (!ARESETN) begin
                        done_a = 1'b0;
                        break;
                    end
                    if (k == a_fall) done_a = 1'b0;
                    if (k == a_lat) begin
                        done_a = 1'b1;
                        merr_a = a_err;
                    end
                end
            end
        end
    end

    always @(negedge tb_ACLK) begin
        if (ARESETN) begin
            if (init_a) begin
                check("a_init_gap", 32'(prev_init_a), 32'd0);
                check("a_grant_onehot", 32'($onehot(grant_a)), 32'd1);
                n_init_a++;
                init_cyc_a = cyc;
            end
            prev_init_a = init_a;
            if (req_done_a != '0) begin
                if (q_a.size() == 0) begin
                    check("a_unexpected_done", 32'(req_done_a), 32'd0);
                end else begin
                    ea = q_a.pop_front();
                    compare("a", ea, req_done_a, req_err_a, txn_a, errc_a, sticky_a,
                            cyc - init_cyc_a);
                end
            end
        end
    end

    always @(negedge tb_ACLK) begin
        if (ARESETN) begin
            if (init_b) begin
                check("b_init_gap", 32'(prev_init_b), 32'd0);
                init_cyc_b = cyc;
            end
            prev_init_b = init_b;
            if (req_done_b != '0) begin
                if (q_b.size() == 0) begin
                    check("b_unexpected_done", 32'(req_done_b), 32'd0);
                end else begin
                    eb = q_b.pop_front();
                    compare("b", eb, req_done_b, req_err_b, txn_b, errc_b, sticky_b,
                            cyc - init_cyc_b);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int n0;
        int exp_txn;
        int exp_errc;

        ARESETN = 1'b0;
        req_a   = '0;
        req_b   = '0;
        done_b  = 1'b0;
        merr_b  = 1'b0;
        repeat (3) @(posedge tb_ACLK);
        #1;

        // Reset state
        check("rst_grant", 32'(grant_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_init", 32'(init_a), 32'd0);
        check("rst_req_done", 32'(req_done_a), 32'd0);
        check("rst_req_err", 32'(req_err_a), 32'd0);
        check("rst_sticky", 32'(sticky_a), 32'd0);
        check("rst_txn_count", 32'(txn_a), 32'd0);
        check("rst_err_count", 32'(errc_a), 32'd0);
        ARESETN = 1'b1;
        @(posedge tb_ACLK);
        #1;

        // Fairness: all four requesting, eight transactions
        exp_txn  = 0;
        exp_errc = 0;
        a_lat = 3; a_fall = 1; a_err = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp_txn++;
            q_a.push_back(mk(N'(1 << (i % N)), 1'b0, exp_txn, exp_errc, 1'b0, 4));
        end
        n0 = n_init_a;
        req_a = 4'b1111;
        for (int i = 0; i < 8; i++) wait_sig(0, 40, "fair_done_seen");
        @(posedge tb_ACLK);
        #1;
        req_a = '0;
        check("fair_init_pulses", n_init_a - n0, 8);

        // Single request, done 20 cycles after start
        a_lat = 20;
        exp_txn++;
        q_a.push_back(mk(4'b0001, 1'b0, exp_txn, exp_errc, 1'b0, 21));
        req_a = 4'b0001;
        wait_sig(0, 60, "single_done_seen");
        @(posedge tb_ACLK);
        #1;
        req_a = '0;

        // Error path on requester 2
        a_lat = 5; a_err = 1'b1;
        exp_txn++;
        exp_errc++;
        q_a.push_back(mk(4'b0100, 1'b1, exp_txn, exp_errc, 1'b0, 6));
        req_a = 4'b0100;
        wait_sig(0, 40, "err_done_seen");
        @(posedge tb_ACLK);
        #1;
        req_a = '0;
        a_err = 1'b0;

        // Stale done: level still high at start, falls at +2, rises at +10
        a_fall = 2; a_lat = 10;
        exp_txn++;
        q_a.push_back(mk(4'b0010, 1'b0, exp_txn, exp_errc, 1'b0, 11));
        req_a = 4'b0010;
        wait_sig(0, 40, "stale_done_seen");
        @(posedge tb_ACLK);
        #1;
        req_a = '0;
        a_fall = 1;

        // Reset in the middle of WAIT
        a_lat = 1000;
        req_a = 4'b1000;
        repeat (8) @(posedge tb_ACLK);
        #3;
        check("pre_rst_busy", 32'(busy_a), 32'd1);
        ARESETN = 1'b0;
        #1;
        check("async_rst_grant", 32'(grant_a), 32'd0);
        check("async_rst_busy", 32'(busy_a), 32'd0);
        check("async_rst_init", 32'(init_a), 32'd0);
        check("async_rst_txn_count", 32'(txn_a), 32'd0);
        check("async_rst_err_count", 32'(errc_a), 32'd0);
        req_a = '0;
        repeat (2) @(posedge tb_ACLK);
        #1;
        ARESETN = 1'b1;
        a_lat = 3;
        q_a.push_back(mk(4'b0001, 1'b0, 1, 0, 1'b0, 4));
        q_a.push_back(mk(4'b0010, 1'b0, 2, 0, 1'b0, 4));
        req_a = 4'b1111;
        wait_sig(0, 40, "post_rst_done0_seen");
        wait_sig(0, 40, "post_rst_done1_seen");
        @(posedge tb_ACLK);
        #1;
        req_a = '0;

        // dut_b: done edge coincides with the timeout terminal count
        q_b.push_back(mk(4'b0001, 1'b0, 1, 0, 1'b0, 17));
        req_b = 4'b0001;
        wait_sig(2, 10, "b_simul_init_seen");
        repeat (16) @(posedge tb_ACLK);
        #1;
        done_b = 1'b1;
        merr_b = 1'b0;
        wait_sig(1, 30, "b_simul_done_seen");
        @(posedge tb_ACLK);
        #1;
        req_b = '0;

        // dut_b: done never rises (stale high level) -> timeout
        q_b.push_back(mk(4'b0010, 1'b1, 2, 1, 1'b1, 17));
        req_b = 4'b0010;
        wait_sig(1, 40, "b_timeout_done_seen");
        @(posedge tb_ACLK);
        #1;
        req_b = '0;

        // dut_b: next request still launches and completes normally
        q_b.push_back(mk(4'b0100, 1'b0, 3, 1, 1'b1, 5));
        req_b = 4'b0100;
        wait_sig(2, 10, "b_after_tmo_init_seen");
        @(posedge tb_ACLK);
        #1;
        done_b = 1'b0;
        repeat (3) @(posedge tb_ACLK);
        #1;
        done_b = 1'b1;
        wait_sig(1, 20, "b_after_tmo_done_seen");
        @(posedge tb_ACLK);
        #1;
        req_b = '0;

        repeat (5) @(negedge tb_ACLK);
        check("a_queue_drained", q_a.size(), 0);
        check("b_queue_drained", q_b.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
